// File: rtl/if_predecode_pkg.sv
// Shared constants, RV32I field encoders and the state type for the fetch predecode stage.
package if_predecode_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_LW  = 3'd2, F3_XOR = 3'd4;
    localparam logic [2:0] F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1;

    localparam logic [1:0] Q0 = 2'b00, Q1 = 2'b01, Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'd0, C0_LW = 3'd2, C0_SW = 3'd6;
    localparam logic [2:0] C1_ADDI = 3'd0, C1_JAL = 3'd1, C1_LI = 3'd2, C1_LUI = 3'd3;
    localparam logic [2:0] C1_ALU  = 3'd4, C1_J   = 3'd5, C1_BEQZ = 3'd6;
    localparam logic [2:0] C2_SLLI = 3'd0, C2_LWSP = 3'd2, C2_JR_MV = 3'd4, C2_SWSP = 3'd6;

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    function automatic logic [4:0] creg(input logic [2:0] r);
        return {2'b01, r};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    // Branch and jump offsets are passed without their always-zero bit 0.
    function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
    endfunction

endpackage

// File: rtl/if_predecode_if.sv
// FIFO-side and ID-side signals of the predecode stage bundled into one interface.
interface if_predecode_if;
    logic [31:0] ir;
    logic [2:0]  ir_hw_cnt;
    logic        taken;
    logic [31:0] re_addr;
    logic [1:0]  drain_cnt;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_is_rvc;
    logic        id_illegal;

    modport master (
        input  ir, ir_hw_cnt, taken, re_addr, id_ready,
        output drain_cnt, id_valid, id_instr, id_pc, id_is_rvc, id_illegal
    );

    modport slave (
        output ir, ir_hw_cnt, taken, re_addr, id_ready,
        input  drain_cnt, id_valid, id_instr, id_pc, id_is_rvc, id_illegal
    );
endinterface

// File: rtl/if_predecode_rvc_expand.sv
// Combinational RV32C to RV32I expander; F/D and reserved encodings raise illegal.
module if_predecode_rvc_expand
    import if_predecode_pkg::*;
(
    input  logic [15:0] c_instr,
    output logic [31:0] x_instr,
    output logic        illegal
);

    logic [15:0] c;
    logic [2:0]  f3;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [5:0]  imm6;
    logic [11:0] imm6_sx, mem_imm, lwsp_imm, swsp_imm, addi4spn_imm, addi16sp_imm;
    logic [19:0] lui_imm;
    logic [20:1] j_off;
    logic [12:1] b_off;

    assign c            = c_instr;
    assign f3           = c[15:13];
    assign rd           = c[11:7];
    assign rs2          = c[6:2];
    assign rdp          = creg(c[4:2]);
    assign rs1p         = creg(c[9:7]);
    assign imm6         = {c[12], c[6:2]};
    assign imm6_sx      = {{6{c[12]}}, imm6};
    assign mem_imm      = {5'b0, c[5], c[12:10], c[6], 2'b00};
    assign lwsp_imm     = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    assign swsp_imm     = {4'b0, c[8:7], c[12:9], 2'b00};
    assign addi4spn_imm = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign addi16sp_imm = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
    assign lui_imm      = {{14{c[12]}}, imm6};
    assign j_off        = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    assign b_off        = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};

    always_comb begin
        x_instr = NOP;
        illegal = 1'b0;
        case (c[1:0])
            Q0: case (f3)
                C0_ADDI4SPN: if (addi4spn_imm == 12'd0) illegal = 1'b1;
                             else x_instr = enc_i(addi4spn_imm, 5'd2, F3_ADD, rdp, OP_IMM);
                C0_LW:       x_instr = enc_i(mem_imm, rs1p, F3_LW, rdp, OP_LOAD);
                C0_SW:       x_instr = enc_s(mem_imm, rdp, rs1p, F3_LW);
                default:     illegal = 1'b1;
            endcase
            Q1: case (f3)
                C1_ADDI: x_instr = enc_i(imm6_sx, rd, F3_ADD, rd, OP_IMM);
                C1_JAL:  x_instr = enc_j(j_off, 5'd1);
                C1_LI:   x_instr = enc_i(imm6_sx, 5'd0, F3_ADD, rd, OP_IMM);
                C1_LUI: begin
                    if (rd == 5'd2) begin
                        if (addi16sp_imm == 12'd0) illegal = 1'b1;
                        else x_instr = enc_i(addi16sp_imm, 5'd2, F3_ADD, 5'd2, OP_IMM);
                    end else if (imm6 == 6'd0) illegal = 1'b1;
                    else x_instr = {lui_imm, rd, OP_LUI};
                end
                // shamt[5] set and the W-forms are reserved on RV32
                C1_ALU: case (c[11:10])
                    2'b00: if (c[12]) illegal = 1'b1;
                           else x_instr = enc_r(7'b0000000, imm6[4:0], rs1p, F3_SR, rs1p, OP_IMM);
                    2'b01: if (c[12]) illegal = 1'b1;
                           else x_instr = enc_r(7'b0100000, imm6[4:0], rs1p, F3_SR, rs1p, OP_IMM);
                    2'b10: x_instr = enc_i(imm6_sx, rs1p, F3_AND, rs1p, OP_IMM);
                    default: if (c[12]) illegal = 1'b1;
                        else case (c[6:5])
                            2'b00:   x_instr = enc_r(7'b0100000, rdp, rs1p, F3_ADD, rs1p, OP_OP);
                            2'b01:   x_instr = enc_r(7'b0000000, rdp, rs1p, F3_XOR, rs1p, OP_OP);
                            2'b10:   x_instr = enc_r(7'b0000000, rdp, rs1p, F3_OR,  rs1p, OP_OP);
                            default: x_instr = enc_r(7'b0000000, rdp, rs1p, F3_AND, rs1p, OP_OP);
                        endcase
                endcase
                C1_J:    x_instr = enc_j(j_off, 5'd0);
                C1_BEQZ: x_instr = enc_b(b_off, 5'd0, rs1p, F3_BEQ);
                default: x_instr = enc_b(b_off, 5'd0, rs1p, F3_BNE);
            endcase
            Q2: case (f3)
                C2_SLLI: if (c[12]) illegal = 1'b1;
                         else x_instr = enc_r(7'b0000000, imm6[4:0], rd, F3_SLL, rd, OP_IMM);
                C2_LWSP: if (rd == 5'd0) illegal = 1'b1;
                         else x_instr = enc_i(lwsp_imm, 5'd2, F3_LW, rd, OP_LOAD);
                C2_JR_MV: begin
                    if (rs2 != 5'd0)
                        x_instr = enc_r(7'b0000000, rs2, c[12] ? rd : 5'd0, F3_ADD, rd, OP_OP);
                    else if (rd != 5'd0)
                        x_instr = enc_i(12'd0, rd, 3'd0, {4'd0, c[12]}, OP_JALR);
                    else if (c[12]) x_instr = EBREAK;
                    else illegal = 1'b1;
                end
                C2_SWSP: x_instr = enc_s(swsp_imm, rs2, 5'd2, F3_LW);
                default: illegal = 1'b1;
            endcase
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/if_predecode.sv
// Fetch predecode: length decode, RVC expansion, fetch PC and the registered ID handoff.
module if_predecode
    import if_predecode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          RVC_EN   = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    if_predecode_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d, id_is_rvc_q, id_is_rvc_d, id_illegal_q, id_illegal_d;
    logic        need2, avail, accept, rvc_illegal, x_illegal;
    logic [31:0] x_instr;
    logic [1:0]  drain;

    if_predecode_rvc_expand u_expand (
        .c_instr (bus.ir[15:0]),
        .x_instr (x_instr),
        .illegal (x_illegal)
    );

    assign need2       = (bus.ir[1:0] == 2'b11);
    assign avail       = need2 ? (bus.ir_hw_cnt >= 3'd2) : (bus.ir_hw_cnt != 3'd0);
    assign rvc_illegal = !RVC_EN || x_illegal;

    // FLUSH blocks acceptance for the cycle after a redirect while the FIFO refills.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_is_rvc_d  = id_is_rvc_q;
        id_illegal_d = id_illegal_q;
        accept       = 1'b0;
        drain        = 2'd0;
        if (state_q == ST_RUN)
            accept = avail && !bus.taken && (!id_valid_q || bus.id_ready);
        if (bus.taken) begin
            state_d    = ST_FLUSH;
            pc_d       = bus.re_addr;
            id_valid_d = 1'b0;
        end else begin
            state_d = ST_RUN;
            if (accept) begin
                drain        = need2 ? 2'd2 : 2'd1;
                id_valid_d   = 1'b1;
                id_pc_d      = pc_q;
                pc_d         = pc_q + (need2 ? 32'd4 : 32'd2);
                id_instr_d   = need2 ? bus.ir : (rvc_illegal ? NOP : x_instr);
                id_is_rvc_d  = !need2;
                id_illegal_d = !need2 && rvc_illegal;
            end else if (bus.id_ready) begin
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_instr_q   <= NOP;
            id_is_rvc_q  <= 1'b0;
            id_illegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_is_rvc_q  <= id_is_rvc_d;
            id_illegal_q <= id_illegal_d;
        end
    end

    assign bus.drain_cnt  = resetn ? drain : 2'd0;
    assign bus.id_valid   = id_valid_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_is_rvc  = id_is_rvc_q;
    assign bus.id_illegal = id_illegal_q;

endmodule

// File: tb/tb_if_predecode.sv
// Directed boundary cases, then a random instruction stream checked against a queue-based FIFO/ID model.
module tb_if_predecode;

    localparam int NCASE = 37;
    localparam logic [15:0] RVC_IN [NCASE] = '{
        16'h40A9, 16'h0000, 16'h852E, 16'h952E, 16'h40C0, 16'hC0C0, 16'h0020, 16'hBFFD,
        16'h2011, 16'hC401, 16'hFCF5, 16'h6285, 16'h717D, 16'h800D, 16'h8489, 16'h997D,
        16'h8C05, 16'h8C25, 16'h8C45, 16'h8C65, 16'h0292, 16'h4092, 16'hC406, 16'h8082,
        16'h9282, 16'h9002, 16'h147D, 16'h0001, 16'h4002, 16'h6000, 16'h2002, 16'h9005,
        16'h9C05, 16'h0004, 16'h8000, 16'h6281, 16'h8002};
    localparam logic [31:0] RVC_EXP [NCASE] = '{
        32'h00A00093, 32'h00000013, 32'h00B00533, 32'h00B50533, 32'h0044A403, 32'h0084A223,
        32'h00810413, 32'hFFFFF06F, 32'h004000EF, 32'h00040463, 32'hFE049EE3, 32'h000012B7,
        32'hFF010113, 32'h00345413, 32'h4024D493, 32'hFFF57513, 32'h40940433, 32'h00944433,
        32'h00946433, 32'h00947433, 32'h00429293, 32'h00412083, 32'h00112423, 32'h00008067,
        32'h000280E7, 32'h00100073, 32'hFFF40413, 32'h00000013, 32'h00000013, 32'h00000013,
        32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
        32'h00000013};
    localparam logic RVC_ILL [NCASE] = '{
        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    typedef struct {
        int          hw;
        logic [31:0] exp;
        logic        ill;
    } ins_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_fail = 0;

    ins_t        iq[$];
    logic [15:0] hq[$];
    logic        m_valid, m_rvc, m_ill, m_flush;
    logic [31:0] m_instr, m_idpc, m_pc;

    if_predecode_if bus();

    if_predecode #(.RESET_PC(32'h0000_0000), .RVC_EN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [2:0] cnt, input logic tk,
                                 input logic [31:0] re, input logic rdy);
        bus.ir        = ir;
        bus.ir_hw_cnt = cnt;
        bus.taken     = tk;
        bus.re_addr   = re;
        bus.id_ready  = rdy;
    endtask

    task automatic expectDrain(input string tag, input logic [1:0] exp);
        @(negedge clk);
        checkOutput(tag, 32'(bus.drain_cnt), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic checkId(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pc, input logic rvc, input logic ill);
        checkOutput({tag, "_valid"}, 32'(bus.id_valid), 32'(v));
        checkOutput({tag, "_instr"}, bus.id_instr, instr);
        checkOutput({tag, "_pc"}, bus.id_pc, pc);
        checkOutput({tag, "_rvc"}, 32'(bus.id_is_rvc), 32'(rvc));
        checkOutput({tag, "_ill"}, 32'(bus.id_illegal), 32'(ill));
    endtask

    task automatic pushRandomInstr();
        ins_t        e;
        logic [31:0] w;
        int          k;
        if ($urandom_range(0, 2) == 0) begin
            w     = $urandom | 32'h3;
            e.hw  = 2;
            e.exp = w;
            e.ill = 1'b0;
            hq.push_back(w[15:0]);
            hq.push_back(w[31:16]);
        end else begin
            k     = $urandom_range(0, NCASE - 1);
            e.hw  = 1;
            e.exp = RVC_EXP[k];
            e.ill = RVC_ILL[k];
            hq.push_back(RVC_IN[k]);
        end
        iq.push_back(e);
    endtask

    initial begin
        int          hw, need;
        logic        tk, rdy, acc;
        logic [31:0] re;

        resetn = 1'b0;
        applyStimulus(32'h00A0_0093, 3'd2, 1'b0, 32'h0, 1'b1);
        #12;
        checkOutput("rst_drain", 32'(bus.drain_cnt), 32'd0);
        checkId("rst", 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);

        // Redirect to 0x100 first so the first accepted instruction sits there.
        applyStimulus(32'h00A0_0093, 3'd2, 1'b1, 32'h100, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("taken_drain", 32'(bus.drain_cnt), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h00A0_0093, 3'd2, 1'b0, 32'h0, 1'b1);
        expectDrain("flush_drain", 2'd0);
        checkOutput("flush_valid", 32'(bus.id_valid), 32'd0);
        expectDrain("t2_drain", 2'd2);
        checkId("t2", 1'b1, 32'h00A0_0093, 32'h100, 1'b0, 1'b0);

        applyStimulus(32'hDEAD_40A9, 3'd1, 1'b0, 32'h0, 1'b1);
        expectDrain("t3_drain", 2'd1);
        checkId("t3", 1'b1, 32'h00A0_0093, 32'h104, 1'b1, 1'b0);

        applyStimulus(32'h00A0_0093, 3'd1, 1'b0, 32'h0, 1'b1);
        expectDrain("t4_wait", 2'd0);
        checkOutput("t4_valid0", 32'(bus.id_valid), 32'd0);
        applyStimulus(32'h00A0_0093, 3'd2, 1'b0, 32'h0, 1'b1);
        expectDrain("t4_go", 2'd2);
        checkId("t4", 1'b1, 32'h00A0_0093, 32'h106, 1'b0, 1'b0);

        applyStimulus(32'h0084_A223, 3'd4, 1'b0, 32'h0, 1'b0);
        expectDrain("t5_stall", 2'd0);
        checkId("t5_hold", 1'b1, 32'h00A0_0093, 32'h106, 1'b0, 1'b0);
        applyStimulus(32'h0084_A223, 3'd4, 1'b0, 32'h0, 1'b1);
        expectDrain("t5_go", 2'd2);
        checkId("t5", 1'b1, 32'h0084_A223, 32'h10A, 1'b0, 1'b0);

        applyStimulus(32'h00A0_0093, 3'd2, 1'b1, 32'h80, 1'b1);
        expectDrain("t6_taken", 2'd0);
        checkOutput("t6_valid0", 32'(bus.id_valid), 32'd0);
        applyStimulus(32'hFFFF_0000, 3'd1, 1'b0, 32'h0, 1'b1);
        expectDrain("t6_flush", 2'd0);
        expectDrain("t6_ill_drain", 2'd1);
        checkId("t6_ill", 1'b1, 32'h13, 32'h80, 1'b1, 1'b1);

        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t1_drain", 32'(bus.drain_cnt), 32'd0);
        checkId("t1", 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);

        applyStimulus(32'h0, 3'd0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_rvc = 1'b0; m_ill = 1'b0; m_flush = 1'b0;
        m_instr = 32'h13; m_idpc = 32'h0; m_pc = 32'h0;

        // Random stream: the bench plays the FIFO and tracks what ID must see.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            while (iq.size() < 3) pushRandomInstr();
            hw = (hq.size() > 5) ? 5 : hq.size();
            if ($urandom_range(0, 3) == 0) hw = $urandom_range(0, hw);
            tk  = ($urandom_range(0, 19) == 0);
            re  = $urandom & 32'hFFFF_FFFE;
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus({hq[1], hq[0]}, 3'(hw), tk, re, rdy);
            need = iq[0].hw;
            acc  = (hw >= need) && !tk && !m_flush && (!m_valid || rdy);
            expectDrain("rnd_drain", acc ? 2'(need) : 2'd0);
            if (tk) begin
                m_valid = 1'b0;
                m_pc    = re;
                m_flush = 1'b1;
                iq.delete();
                hq.delete();
            end else begin
                m_flush = 1'b0;
                if (acc) begin
                    m_valid = 1'b1;
                    m_idpc  = m_pc;
                    m_pc    = m_pc + 32'(2 * need);
                    m_instr = iq[0].exp;
                    m_rvc   = (need == 1);
                    m_ill   = iq[0].ill;
                    void'(iq.pop_front());
                    repeat (need) void'(hq.pop_front());
                end else if (rdy) begin
                    m_valid = 1'b0;
                end
            end
            checkId("rnd", m_valid, m_instr, m_idpc, m_rvc, m_ill);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
